// File: rtl/avst_sum_pkg.sv
// Shared types and elaboration-time checks for the packet-sum stream block.
package avst_sum_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int unsigned MIN_DEPTH = 2;

    function automatic int unsigned out_beats(input int unsigned sum_w, input int unsigned data_w);
        return sum_w / data_w;
    endfunction

    function automatic bit widths_ok(input int unsigned sum_w, input int unsigned data_w);
        return (data_w >= 1) && (sum_w >= data_w) && ((sum_w % data_w) == 0);
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return (depth >= MIN_DEPTH) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/avst_sync_fifo.sv
// Synchronous FIFO with full/empty/count; push and pop on the same edge are both honoured.
module avst_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/avst_pkt_sum.sv
// Streaming packet summer: per-packet modular sum, queued and serialised MSB slice first.
// Optional trailing length beat enabled by defining AVST_SUM_LEN_EN.
module avst_pkt_sum
    import avst_sum_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SUM_W  = 16,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              end_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              end_out,
    output logic              valid_out,
    input  logic              ready_out
);

    localparam int unsigned OUT_BEATS = out_beats(SUM_W, DATA_W);
`ifdef AVST_SUM_LEN_EN
    localparam int unsigned TOTAL_BEATS = OUT_BEATS + 1;
    localparam int unsigned ENTRY_W     = SUM_W + DATA_W;
`else
    localparam int unsigned TOTAL_BEATS = OUT_BEATS;
    localparam int unsigned ENTRY_W     = SUM_W;
`endif
    localparam int unsigned IDX_W = (TOTAL_BEATS > 1) ? $clog2(TOTAL_BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_BEATS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;

    generate
        if (!widths_ok(SUM_W, DATA_W)) begin : g_bad_widths
            $error("avst_pkt_sum: SUM_W must be a multiple of DATA_W and >= DATA_W");
        end
        if (!depth_ok(DEPTH)) begin : g_bad_depth
            $error("avst_pkt_sum: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [SUM_W-1:0]         acc;
    logic [SUM_W-1:0]         sum_next;
    logic [ENTRY_W-1:0]       entry;
    logic                     in_fire;

    logic [ENTRY_W-1:0]       fifo_dout;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     fifo_pop;
    logic                     count_unused;

    state_t                   state;
    state_t                   state_n;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_n;
    logic [ENTRY_W-1:0]       shreg;
    logic                     load;
    logic                     shift;

    // ready_in looks only at registered FIFO state, never at a same-cycle pop
    assign ready_in     = !reset && !fifo_full;
    assign in_fire      = valid_in && ready_in;
    assign sum_next     = acc + SUM_W'(data_in);
    assign count_unused = ^fifo_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (in_fire) begin
            acc <= end_in ? '0 : sum_next;
        end
    end

`ifdef AVST_SUM_LEN_EN
    logic [DATA_W-1:0] len_cnt;
    logic [DATA_W-1:0] len_next;

    assign len_next = len_cnt + DATA_W'(1);
    assign entry    = {sum_next, len_next};

    always_ff @(posedge clk) begin
        if (reset) begin
            len_cnt <= '0;
        end else if (in_fire) begin
            len_cnt <= end_in ? '0 : len_next;
        end
    end
`else
    assign entry = sum_next;
`endif

    avst_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_fire && end_in),
        .din   (entry),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (load) begin
                shreg <= fifo_dout;
            end else if (shift) begin
                shreg <= shreg << DATA_W;
            end
        end
    end

    // On the final beat's transfer a waiting sum is loaded directly, so packets leave without a bubble
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        fifo_pop  = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        valid_out = 1'b0;
        end_out   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                    idx_n    = '0;
                    state_n  = SEND;
                end
            end
            SEND: begin
                valid_out = 1'b1;
                end_out   = (idx == LAST_IDX);
                if (ready_out) begin
                    if (idx == LAST_IDX) begin
                        idx_n = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            load     = 1'b1;
                        end else begin
                            shift   = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        idx_n = idx + IDX_ONE;
                        shift = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign data_out = shreg[ENTRY_W-1 -: DATA_W];

endmodule

// File: tb/tb_avst_pkt_sum.sv
// Self-checking bench for avst_pkt_sum with a packet-level reference model.
module tb_avst_pkt_sum;

    localparam int DW    = 8;
    localparam int SW    = 16;
    localparam int DEPTH = 4;
    localparam int OB    = SW / DW;
`ifdef AVST_SUM_LEN_EN
    localparam int NB = OB + 1;
`else
    localparam int NB = OB;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          end_in;
    logic          valid_in;
    logic          ready_in;
    logic [DW-1:0] data_out;
    logic          end_out;
    logic          valid_out;
    logic          ready_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW:0] obs_q[$];
    int          obs_cyc[$];
    logic [DW:0] exp_q[$];

    avst_pkt_sum #(
        .DATA_W (DW),
        .SUM_W  (SW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .end_in    (end_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .end_out   (end_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    always #5 clk = ~clk;

    // Output beats that will transfer on the next rising edge, recorded as {end, data}
    always @(negedge clk) begin
        cyc++;
        if (!reset && valid_out && ready_out) begin
            obs_q.push_back({end_out, data_out});
            obs_cyc.push_back(cyc);
        end
    end

    // Reference: sum modulo 2^SW, split into DW slices MSB first, optional length beat
    task automatic model_packet(input int unsigned beats[$]);
        longint unsigned s = 0;
        foreach (beats[i]) s += beats[i];
        s = s % (64'd1 << SW);
        for (int k = 0; k < OB; k++) begin
            logic [DW-1:0] b;
            logic          last;
            b    = DW'((s >> (SW - DW * (k + 1))) & ((64'd1 << DW) - 1));
            last = (k == OB - 1) && (NB == OB);
            exp_q.push_back({last, b});
        end
        if (NB != OB) begin
            exp_q.push_back({1'b1, DW'(beats.size() % (1 << DW))});
        end
    endtask

    task automatic clear_q();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic e, output bit ok);
        ok       = 1'b0;
        valid_in = 1'b1;
        data_in  = d;
        end_in   = e;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (ready_in) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        valid_in = 1'b0;
        end_in   = 1'b0;
    endtask

    task automatic send_packet(input int unsigned beats[$], output bit ok);
        bit b_ok;
        ok = 1'b1;
        model_packet(beats);
        for (int i = 0; i < beats.size(); i++) begin
            send_beat(DW'(beats[i]), i == beats.size() - 1, b_ok);
            if (!b_ok) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_beats(input int n, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; end_in = 1'b0; data_in = '0; ready_out = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({ready_in, valid_out, end_out, data_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: ready_in=%b valid_out=%b end_out=%b data_out=%h, required all 0",
                     ready_in, valid_out, end_out, data_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_tests++;
        if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready_in=%b valid_out=%b, required 1 0", ready_in, valid_out);
        end
    endtask

    task automatic test_basic();
        int unsigned pk[$];
        bit ok;
        ready_out = 1'b1;
        clear_q();
        pk = '{'h10, 'h20, 'h30};
        send_packet(pk, ok);
        n_tests++;
        if (!ok || valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_accept_edge: accepted=%b valid_out=%b, required 1 0", ok, valid_out);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (valid_out !== 1'b1 || data_out !== 8'h00 || end_out !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: valid=%b data=%h end=%b, required 1 00 0", valid_out, data_out, end_out);
        end
        wait_beats(NB, ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_beat%0d: got {end,data}=%h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() > 1) begin
            n_tests++;
            if (obs_q[1][DW-1:0] !== 8'h60) begin
                n_fail++;
                $display("FAIL basic_sum_lsb: got %h, required 60", obs_q[1][DW-1:0]);
            end
        end
    endtask

    task automatic test_wrap();
        int unsigned pk[$];
        bit ok, ok2;
        ready_out = 1'b1;
        clear_q();
        pk.delete();
        repeat (258) pk.push_back('hFF);
        send_packet(pk, ok);
        pk.delete();
        repeat (257) pk.push_back('hFF);
        send_packet(pk, ok2);
        wait_beats(2 * NB, ok);
        n_tests++;
        if (!ok || !ok2 || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL wrap_beat%0d: got {end,data}=%h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() >= NB + 2) begin
            n_tests++;
            if (obs_q[1][DW-1:0] !== 8'hFE || obs_q[NB+1][DW-1:0] !== 8'hFF) begin
                n_fail++;
                $display("FAIL wrap_lsb: got %h %h, required FE FF", obs_q[1][DW-1:0], obs_q[NB+1][DW-1:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned pk[$];
        bit ok, ok2;
        ready_out = 1'b1;
        clear_q();
        pk = '{'hAB};
        send_packet(pk, ok);
        pk = '{'hCD};
        send_packet(pk, ok2);
        wait_beats(2 * NB, ok);
        n_tests++;
        if (!ok || !ok2 || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got {end,data}=%h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < obs_cyc.size(); i++) begin
            n_tests++;
            if (obs_cyc[i] != obs_cyc[i-1] + 1) begin
                n_fail++;
                $display("FAIL b2b_bubble%0d: beat cycle %0d, required %0d", i, obs_cyc[i], obs_cyc[i-1] + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int unsigned pk[$];
        bit ok;
        bit all_ok = 1'b1;
        bit held   = 1'b1;
        bit got6   = 1'b0;
        ready_out = 1'b0;
        clear_q();
        for (int v = 1; v <= 5; v++) begin
            pk = '{v};
            send_packet(pk, ok);
            all_ok &= ok;
        end
        n_tests++;
        if (!all_ok || ready_in !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full: accepted_all=%b ready_in=%b, required 1 0", all_ok, ready_in);
        end
        pk = '{6};
        model_packet(pk);
        valid_in = 1'b1; data_in = 8'h06; end_in = 1'b1;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (ready_in !== 1'b0 || valid_out !== 1'b1 || data_out !== 8'h00 || end_out !== 1'b0) held = 1'b0;
        end
        n_tests++;
        if (!held) begin
            n_fail++;
            $display("FAIL bp_hold: ready_in=%b valid=%b data=%h end=%b, required 0 1 00 0",
                     ready_in, valid_out, data_out, end_out);
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ready_in) begin
                @(posedge clk);
                #1;
                got6 = 1'b1;
                break;
            end
        end
        valid_in = 1'b0; end_in = 1'b0;
        n_tests++;
        if (!got6) begin
            n_fail++;
            $display("FAIL bp_accept6: accepted=%b, required 1", got6);
        end
        wait_beats(6 * NB, ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL bp_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp_beat%0d: got {end,data}=%h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int unsigned pk[$];
        bit ok;
        logic [DW:0] exp_l[$];
        ready_out = 1'b0;
        clear_q();
        pk = '{'h07};
        send_packet(pk, ok);
        send_beat(8'h05, 1'b0, ok);
        send_beat(8'h06, 1'b0, ok);
        exp_q.delete();
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (valid_out !== 1'b0 || ready_in !== 1'b0 || data_out !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_during: valid=%b ready_in=%b data=%h, required 0 0 00", valid_out, ready_in, data_out);
        end
        reset = 1'b0;
        ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        obs_q.delete();
        pk = '{'h01};
        send_packet(pk, ok);
        wait_beats(NB, ok);
        exp_l = exp_q;
        n_tests++;
        if (!ok || obs_q.size() != exp_l.size()) begin
            n_fail++;
            $display("FAIL rst_mid_count: got %0d beats, required %0d", obs_q.size(), exp_l.size());
        end
        for (int i = 0; i < exp_l.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL rst_mid_beat%0d: got {end,data}=%h, required %h", i, obs_q[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_random();
        bit rnd_done = 1'b0;
        bit ok = 1'b1;
        clear_q();
        fork
            begin
                int unsigned pk[$];
                bit p_ok;
                for (int p = 0; p < 20; p++) begin
                    pk.delete();
                    repeat ($urandom_range(1, 6)) pk.push_back($urandom_range(0, 255));
                    send_packet(pk, p_ok);
                    ok &= p_ok;
                end
                wait_beats(exp_q.size(), p_ok);
                ok &= p_ok;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    ready_out = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                logic pv = 1'b0, pr = 1'b0;
                logic [DW:0] pb = '0;
                while (!rnd_done) begin
                    @(negedge clk);
                    if (pv && !pr) begin
                        n_tests++;
                        if (valid_out !== 1'b1 || {end_out, data_out} !== pb) begin
                            n_fail++;
                            $display("FAIL rnd_stable: valid=%b {end,data}=%h, required 1 %h", valid_out, {end_out, data_out}, pb);
                        end
                    end
                    pv = valid_out; pr = ready_out; pb = {end_out, data_out};
                end
            end
        join
        ready_out = 1'b1;
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rnd_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rnd_beat%0d: got {end,data}=%h, required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

`ifdef AVST_SUM_LEN_EN
    task automatic test_len();
        int unsigned pk[$];
        bit ok;
        logic [DW:0] want[3];
        want = '{9'h000, 9'h006, 9'h103};
        ready_out = 1'b1;
        clear_q();
        pk = '{'h01, 'h02, 'h03};
        send_packet(pk, ok);
        wait_beats(3, ok);
        n_tests++;
        if (!ok || obs_q.size() != 3) begin
            n_fail++;
            $display("FAIL len_count: got %0d beats, required 3", obs_q.size());
        end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== want[i]) begin
                n_fail++;
                $display("FAIL len_beat%0d: got {end,data}=%h, required %h", i, obs_q[i], want[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef AVST_SUM_LEN_EN
        test_len();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
